imem_ctrl: RTL and testbench

Instruction-memory controller between the core fetch port, the word-addressed instruction memory array, and a byte-stream program loader. In RUN it passes fetch addresses through to the memory. In LOAD it holds the core in reset, assembles incoming bytes into little-endian 32-bit words and writes them sequentially from word 0. When the load finishes it releases the core.

---
 rtl/imem_ctrl.sv | 151 +++++++++++++++
 tb/tb_imem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: fetch pass-through in RUN, little-endian byte-stream loader otherwise.
// Optional byte checksum accumulator enabled by defining IMEM_CTRL_CHECKSUM_EN.
module imem_ctrl #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       fetch_addr_i,
    output logic [31:0]       fetch_instr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic [ADDR_W:0]   ld_words_o,
    output logic [7:0]        ld_sum_o,
    output logic              core_rst_no
);

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] WORDS_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wptr;
    logic [1:0]        r_bidx;
    logic [31:0]       r_word;
    logic [31:0]       w_word_nxt;
    logic              r_last;
    logic [ADDR_W:0]   r_words;
    logic              r_err;
    logic              r_core_rst_n;
    logic              w_accept;
    logic              w_ovf;
    logic              w_unused;

    assign w_unused = ^{fetch_addr_i[31:ADDR_W+2], fetch_addr_i[1:0]};
    assign w_ovf    = (r_words == WORDS_FULL);

    // A new word starts from zero so a short final word has zero upper bytes.
    always_comb begin
        w_word_nxt = (r_bidx == 2'd0) ? '0 : r_word;
        w_word_nxt[{r_bidx, 3'b000} +: 8] = ld_data_i;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ld_start_i) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_accept = ld_valid_i;
                if (ld_valid_i) begin
                    if (w_ovf) begin
                        if (ld_last_i) w_next = S_DONE;
                    end else if (r_bidx == 2'd3 || ld_last_i) begin
                        w_next = S_WRITE;
                    end
                end
            end
            S_WRITE: w_next = r_last ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_RUN;
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_RUN;
            r_wptr       <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_words      <= '0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_core_rst_n <= (w_next == S_RUN);
            case (r_state)
                S_RUN: begin
                    if (ld_start_i) begin
                        r_wptr  <= '0;
                        r_bidx  <= '0;
                        r_words <= '0;
                        r_err   <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_ovf) begin
                            r_err <= 1'b1;
                        end else begin
                            r_word <= w_word_nxt;
                            r_bidx <= r_bidx + 2'd1;
                            r_last <= ld_last_i;
                        end
                    end
                end
                S_WRITE: begin
                    r_wptr  <= r_wptr + 1'b1;
                    r_words <= r_words + 1'b1;
                    r_bidx  <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_CTRL_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum <= '0;
        end else if (r_state == S_RUN && ld_start_i) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + ld_data_i;
        end
    end

    assign ld_sum_o = r_sum;
`else
    assign ld_sum_o = '0;
`endif

    assign mem_addr_o    = (r_state == S_WRITE) ? r_wptr : fetch_addr_i[ADDR_W+1:2];
    assign mem_wdata_o   = r_word;
    assign mem_we_o      = (r_state == S_WRITE);
    assign fetch_instr_o = (r_state == S_RUN) ? mem_rdata_i : NOP_INSTR;
    assign ld_ready_o    = (r_state == S_LOAD);
    assign ld_busy_o     = (r_state != S_RUN);
    assign ld_done_o     = (r_state == S_DONE);
    assign ld_err_o      = r_err;
    assign ld_words_o    = r_words;
    assign core_rst_no   = r_core_rst_n;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl at ADDR_W=2: fetch table, directed loads, random loads vs a byte-list model.
module tb_imem_ctrl;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   fetch_addr_i = '0;
    logic [31:0]   fetch_instr_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i;
    logic [31:0]   mem_wdata_o;
    logic          mem_we_o;
    logic          ld_start_i = 1'b0;
    logic          ld_valid_i = 1'b0;
    logic [7:0]    ld_data_i = '0;
    logic          ld_last_i = 1'b0;
    logic          ld_ready_o;
    logic          ld_busy_o;
    logic          ld_done_o;
    logic          ld_err_o;
    logic [AW:0]   ld_words_o;
    logic [7:0]    ld_sum_o;
    logic          core_rst_no;

    always #5 clk = ~clk;

    imem_ctrl #(.ADDR_W(AW), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_addr_i(fetch_addr_i), .fetch_instr_o(fetch_instr_o),
        .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
        .ld_last_i(ld_last_i), .ld_ready_o(ld_ready_o), .ld_busy_o(ld_busy_o),
        .ld_done_o(ld_done_o), .ld_err_o(ld_err_o), .ld_words_o(ld_words_o),
        .ld_sum_o(ld_sum_o), .core_rst_no(core_rst_no)
    );

    // Memory array model with a preload port
    logic [31:0] mem [DEPTH];
    logic [31:0] pre [DEPTH];
    logic        pre_en = 1'b0;
    assign mem_rdata_i = mem[mem_addr_o];
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pre[i];
        end else if (mem_we_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: expected results derived from the byte list alone
    logic [7:0]  bq [$];
    logic [31:0] exp_mem [DEPTH];
    int          exp_words;
    logic        exp_err;
    logic [7:0]  exp_sum;

    task automatic model_load();
        int n;
        logic [31:0] w;
        logic [7:0]  s;
        n = bq.size();
        s = 8'h00;
        foreach (bq[i]) s = s + bq[i];
`ifdef IMEM_CTRL_CHECKSUM_EN
        exp_sum = s;
`else
        exp_sum = 8'h00;
`endif
        exp_err   = (n > 4 * DEPTH);
        exp_words = (n + 3) / 4;
        if (exp_words > DEPTH) exp_words = DEPTH;
        for (int wi = 0; wi < exp_words; wi++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * wi + k < n) w[8*k +: 8] = bq[4*wi + k];
            exp_mem[wi] = w;
        end
    endtask

    task automatic run_load(input int stall_pct);
        int  idx, nwr, done_c, n;
        bit  hold_bad;
        idx = 0; nwr = 0; done_c = 0; hold_bad = 0;
        n = bq.size();
        model_load();
        @(negedge clk); ld_start_i = 1'b1;
        @(negedge clk); ld_start_i = 1'b0;
        chk("err_cleared_on_start", ld_err_o, 0);
        chk("words_cleared_on_start", ld_words_o, 0);
        for (int c = 1; c <= 400; c++) begin
            if (ld_done_o) begin
                done_c = c;
                if (core_rst_no !== 1'b0 || fetch_instr_o !== NOP) hold_bad = 1;
                break;
            end
            if (core_rst_no !== 1'b0 || fetch_instr_o !== NOP || ld_busy_o !== 1'b1) hold_bad = 1;
            if (mem_we_o) nwr++;
            if (idx < n && $urandom_range(99) >= stall_pct) begin
                ld_valid_i = 1'b1;
                ld_data_i  = bq[idx];
                ld_last_i  = (idx == n - 1);
            end else begin
                ld_valid_i = 1'b0;
                ld_data_i  = 8'($urandom);
                ld_last_i  = 1'($urandom);
            end
            if (ld_valid_i && ld_ready_o) idx++;
            @(negedge clk);
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        chk("done_seen", 32'(done_c != 0), 1);
        if (stall_pct == 0) chk("done_cycle", done_c, n + exp_words + 1);
        chk("core_held_nop", 32'(hold_bad), 0);
        chk("write_count", nwr, exp_words);
        @(negedge clk);
        chk("done_one_cycle", ld_done_o, 0);
        chk("core_released", core_rst_no, 1);
        chk("busy_after", ld_busy_o, 0);
        chk("ld_words", ld_words_o, exp_words);
        chk("ld_err", ld_err_o, exp_err);
        chk("ld_sum", ld_sum_o, exp_sum);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), mem[i], exp_mem[i]);
    endtask

    typedef struct {
        logic [31:0]   addr;
        logic [AW-1:0] exp_maddr;
        logic [31:0]   exp_instr;
    } fvec_t;

    fvec_t tbl [5];

    initial begin
        pre[0] = 32'hA000_0001; pre[1] = 32'hB111_0002;
        pre[2] = 32'hC222_0003; pre[3] = 32'hD333_0004;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = pre[i];
        tbl[0] = '{32'h0000_0008, 2'd2, 32'hC222_0003};
        tbl[1] = '{32'h0000_0000, 2'd0, 32'hA000_0001};
        tbl[2] = '{32'h0000_0014, 2'd1, 32'hB111_0002};
        tbl[3] = '{32'hFFFF_FFFC, 2'd3, 32'hD333_0004};
        tbl[4] = '{32'h0000_002F, 2'd3, 32'hD333_0004};

        // Reset values
        pre_en = 1'b1;
        repeat (2) @(negedge clk);
        pre_en = 1'b0;
        chk("rst_core_rst_no", core_rst_no, 0);
        chk("rst_done", ld_done_o, 0);
        chk("rst_err", ld_err_o, 0);
        chk("rst_words", ld_words_o, 0);
        chk("rst_sum", ld_sum_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_ready", ld_ready_o, 0);
        chk("rst_busy", ld_busy_o, 0);
        rst_n = 1'b1;
        #1 chk("core_rst_before_edge", core_rst_no, 0);
        @(posedge clk); #1;
        chk("core_rst_after_edge", core_rst_no, 1);

        // Fetch pass-through table
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            fetch_addr_i = tbl[i].addr;
            ld_valid_i = 1'b1;
            #1;
            chk($sformatf("fetch_addr[%0d]", i), mem_addr_o, tbl[i].exp_maddr);
            chk($sformatf("fetch_instr[%0d]", i), fetch_instr_o, tbl[i].exp_instr);
            chk($sformatf("run_ready[%0d]", i), ld_ready_o, 0);
        end
        ld_valid_i = 1'b0;

        // Two full words
        bq = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load(0);
        chk("word0_const", mem[0], 32'h0010_0513);
        chk("word1_const", mem[1], 32'h0020_0593);

        // Partial final word
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load(0);
        chk("partial_const", mem[1], 32'h0000_0605);

        // Same bytes with loader stalls
        bq = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load(50);

        // Overflow: 17 bytes into a 4-word memory
        bq.delete();
        for (int i = 0; i < 17; i++) bq.push_back(8'(8'h40 + i));
        run_load(0);
        chk("ovf_word0_kept", mem[0], 32'h4342_4140);

        // Next load clears the error; checksum wrap
        bq = '{8'hFF, 8'h02};
        run_load(0);

        // Reset in the middle of a load
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
        @(negedge clk); ld_start_i = 1'b1;
        @(negedge clk); ld_start_i = 1'b0;
        ld_valid_i = 1'b1; ld_data_i = 8'h11;
        @(negedge clk); ld_data_i = 8'h22;
        @(negedge clk); ld_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_core_rst", core_rst_no, 0);
        chk("abort_busy", ld_busy_o, 0);
        chk("abort_we", mem_we_o, 0);
        chk("abort_words", ld_words_o, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_release", core_rst_no, 1);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("abort_mem[%0d]", i), mem[i], exp_mem[i]);

        // Random loads
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(20, 1);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            run_load((t % 2 == 0) ? 0 : 30);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
